imu_spi_reader: RTL and testbench

//  Front-end for the 6-axis IMU. After power-up it configures the IMU over SPI.
//  On each data-ready INT it reads the pitch-rate and AZ register pairs.
//  It presents signed 16-bit ptch_rt / AZ with a one-cycle vld pulse, directly

---
 rtl/imu_spi_reader_pkg.sv | 35 +++
 rtl/imu_spi_reader_spi.sv | 81 ++++++++
 rtl/imu_spi_reader.sv | 172 +++++++++++++++++
 tb/tb_imu_spi_reader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imu_spi_reader_pkg.sv
// Shared types and constants for the IMU SPI reader: FSM states, IMU init
// commands, read-register addresses and SPI frame width.
package imu_pkg;

    localparam int FRAME_W = 16;

    typedef enum logic [3:0] {
        PWRUP,
        INIT1,
        INIT2,
        INIT3,
        INIT4,
        WAIT_INT,
        RD_PL,
        RD_PH,
        RD_AL,
        RD_AH
    } state_t;

    localparam logic [FRAME_W-1:0] CMD_INIT1 = 16'h0D02;  // INT1 on data-ready
    localparam logic [FRAME_W-1:0] CMD_INIT2 = 16'h1053;  // accel 208 Hz
    localparam logic [FRAME_W-1:0] CMD_INIT3 = 16'h1150;  // gyro 208 Hz
    localparam logic [FRAME_W-1:0] CMD_INIT4 = 16'h1460;  // rounding

    localparam logic [7:0] ADDR_PL = 8'hA2;
    localparam logic [7:0] ADDR_PH = 8'hA3;
    localparam logic [7:0] ADDR_AL = 8'hAC;
    localparam logic [7:0] ADDR_AH = 8'hAD;

    // Read frame: address byte first, second byte is a don't-care filler.
    function automatic logic [FRAME_W-1:0] rd_cmd(input logic [7:0] addr);
        return {addr, 8'h00};
    endfunction

endpackage

// File: rtl/imu_spi_reader_spi.sv
// SPI monarch, mode 3, 16-bit frames. One wrt pulse runs one frame; done
// pulses as SS_n rises and rd_data holds the last byte received.
module spi_mnrch
    import imu_pkg::*;
#(
    parameter int SCLK_DIV_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wrt,
    input  logic [FRAME_W-1:0] wt_data,
    output logic               done,
    output logic [7:0]         rd_data,
    output logic               SS_n,
    output logic               SCLK,
    output logic               MOSI,
    input  logic               MISO
);

    localparam int CNT_W = $clog2(FRAME_W) + 1;

    logic                  busy;
    logic [SCLK_DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0]      rise_cnt;
    logic [FRAME_W-1:0]    shft;
    logic                  miso_smpl;
    logic                  fall_now;
    logic                  rise_now;

    assign fall_now = busy && (div_cnt == '1);
    assign rise_now = busy && (div_cnt == {1'b0, {(SCLK_DIV_W-1){1'b1}}});
    assign MOSI     = busy & shft[FRAME_W-1];
    assign rd_data  = shft[7:0];

    // The shift register doubles as receive buffer: each transmitted bit
    // leaves at the MSB while the bit sampled on the previous rise enters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            div_cnt   <= '1;
            rise_cnt  <= '0;
            shft      <= '0;
            miso_smpl <= 1'b0;
            SS_n      <= 1'b1;
            SCLK      <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (wrt) begin
                    busy     <= 1'b1;
                    SS_n     <= 1'b0;
                    shft     <= wt_data;
                    div_cnt  <= '1;
                    rise_cnt <= '0;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
                if (rise_now) begin
                    SCLK      <= 1'b1;
                    miso_smpl <= MISO;
                    rise_cnt  <= rise_cnt + 1'b1;
                end
                if (fall_now) begin
                    if (rise_cnt == CNT_W'(FRAME_W)) begin
                        busy <= 1'b0;
                        SS_n <= 1'b1;
                        done <= 1'b1;
                        shft <= {shft[FRAME_W-2:0], miso_smpl};
                    end else begin
                        SCLK <= 1'b0;
                        // first fall only opens the frame; MSB is already on MOSI
                        if (rise_cnt != '0)
                            shft <= {shft[FRAME_W-2:0], miso_smpl};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/imu_spi_reader.sv
// IMU front-end: configures the IMU after power-up, then reads pitch rate and
// AZ on each data-ready INT. Optional WAIT_INT timeout under IMU_TIMEOUT_EN.
//
// state    | meaning
// PWRUP    | wait PWRUP_CYC cycles before talking to the IMU
// INIT1..4 | write one configuration register each
// WAIT_INT | idle until synchronized INT is high (or timeout)
// RD_PL/PH | read pitch-rate low / high byte
// RD_AL/AH | read accel Z low / high byte, then publish both words
module imu_spi_reader
    import imu_pkg::*;
#(
    parameter int PWRUP_CYC  = 65536,
    parameter int SCLK_DIV_W = 5
`ifdef IMU_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 2**20
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        vld,
    output logic        imu_err
);

    localparam int PWR_W = $clog2(PWRUP_CYC) + 1;

    state_t             state;
    logic               wrt;
    logic [FRAME_W-1:0] wt_data;
    logic               done;
    logic [7:0]         rd_data;
    logic [PWR_W-1:0]   pwr_cnt;
    logic [7:0]         pl_hold;
    logic [7:0]         ph_hold;
    logic [7:0]         al_hold;
    logic               int_meta;
    logic               int_sync;

`ifdef IMU_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TO_W-1:0] to_cnt;
    logic            err_q;
    assign imu_err = err_q;
`else
    assign imu_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_meta <= 1'b0;
            int_sync <= 1'b0;
        end else begin
            int_meta <= INT;
            int_sync <= int_meta;
        end
    end

    spi_mnrch #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .wt_data (wt_data),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PWRUP;
            wrt     <= 1'b0;
            wt_data <= '0;
            pwr_cnt <= '0;
            pl_hold <= '0;
            ph_hold <= '0;
            al_hold <= '0;
            ptch_rt <= '0;
            AZ      <= '0;
            vld     <= 1'b0;
`ifdef IMU_TIMEOUT_EN
            to_cnt  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            wrt <= 1'b0;
            vld <= 1'b0;
`ifdef IMU_TIMEOUT_EN
            to_cnt <= (state == WAIT_INT) ? to_cnt + 1'b1 : '0;
`endif
            case (state)
                PWRUP: begin
                    if (pwr_cnt == PWR_W'(PWRUP_CYC - 1)) begin
                        state   <= INIT1;
                        wrt     <= 1'b1;
                        wt_data <= CMD_INIT1;
                    end else begin
                        pwr_cnt <= pwr_cnt + 1'b1;
                    end
                end
                INIT1: if (done) begin
                    state   <= INIT2;
                    wrt     <= 1'b1;
                    wt_data <= CMD_INIT2;
                end
                INIT2: if (done) begin
                    state   <= INIT3;
                    wrt     <= 1'b1;
                    wt_data <= CMD_INIT3;
                end
                INIT3: if (done) begin
                    state   <= INIT4;
                    wrt     <= 1'b1;
                    wt_data <= CMD_INIT4;
                end
                INIT4: if (done) state <= WAIT_INT;
                WAIT_INT: begin
                    if (int_sync) begin
                        state   <= RD_PL;
                        wrt     <= 1'b1;
                        wt_data <= rd_cmd(ADDR_PL);
                    end
`ifdef IMU_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        err_q   <= 1'b1;
                        state   <= INIT1;
                        wrt     <= 1'b1;
                        wt_data <= CMD_INIT1;
                    end
`endif
                end
                RD_PL: if (done) begin
                    pl_hold <= rd_data;
                    state   <= RD_PH;
                    wrt     <= 1'b1;
                    wt_data <= rd_cmd(ADDR_PH);
                end
                RD_PH: if (done) begin
                    ph_hold <= rd_data;
                    state   <= RD_AL;
                    wrt     <= 1'b1;
                    wt_data <= rd_cmd(ADDR_AL);
                end
                RD_AL: if (done) begin
                    al_hold <= rd_data;
                    state   <= RD_AH;
                    wrt     <= 1'b1;
                    wt_data <= rd_cmd(ADDR_AH);
                end
                // Both words update together so the integrator never sees a mix.
                RD_AH: if (done) begin
                    ptch_rt <= {ph_hold, pl_hold};
                    AZ      <= {rd_data, al_hold};
                    vld     <= 1'b1;
                    state   <= WAIT_INT;
                end
                default: state <= PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_imu_spi_reader.sv
// Self-checking bench for imu_spi_reader with a behavioural SPI IMU model and
// scoreboard queues for MOSI frames and published samples.
module tb_imu_spi_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        MISO = 1'b0;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic        vld;
    logic        imu_err;

    always #5 clk = ~clk;

    imu_spi_reader #(
        .PWRUP_CYC  (64),
        .SCLK_DIV_W (5)
`ifdef IMU_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(256)
`endif
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .MISO    (MISO),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .ptch_rt (ptch_rt),
        .AZ      (AZ),
        .vld     (vld),
        .imu_err (imu_err)
    );

    typedef struct packed { logic [15:0] val; logic [15:0] mask; } frm_t;
    typedef struct packed { logic [15:0] pr;  logic [15:0] az;   } out_t;

    frm_t exp_frm[$];
    out_t exp_out[$];

    int checks = 0;
    int failures = 0;

    logic [15:0] mdl_pr = 16'h0;
    logic [15:0] mdl_az = 16'h0;

    // monitor state
    int          cyc = 0;
    int          bits = 0;
    int          falls = 0;
    logic [15:0] rx = 16'h0;
    logic [15:0] tx = 16'h0;
    logic        ss_prev = 1'b1;
    logic        sclk_prev = 1'b1;
    logic        err_prev = 1'b0;
    int          err_cyc = 0;
    int          last_rise_cyc = 0;
    int          started = 0;
    int          frames_done = 0;
    int          rd_frames = 0;
    int          last_rd = 0;
    int          vld_cnt = 0;
    int          hold_err = 0;
    logic [15:0] last_pr = 16'h0;
    logic [15:0] last_az = 16'h0;
    int          hi_run = 0;
    int          min_gap = 1000;
    bit          seen_frame = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [7:0] reg_rd(input logic [7:0] cmd, input logic [15:0] pr,
                                          input logic [15:0] az);
        case (cmd)
            8'hA2:   return pr[7:0];
            8'hA3:   return pr[15:8];
            8'hAC:   return az[7:0];
            8'hAD:   return az[15:8];
            default: return 8'h00;
        endcase
    endfunction

    // IMU model, frame scoreboard and output monitor, all sampled mid-cycle.
    always @(negedge clk) begin
        frm_t ef;
        out_t eo;
        cyc++;
        if (ss_prev && !SS_n) begin
            bits = 0; falls = 0; rx = 16'h0; tx = 16'h0; started++;
        end
        if (!ss_prev && SS_n) begin
            last_rise_cyc = cyc;
            if (bits == 16) begin
                frames_done++;
                if (rx[15]) rd_frames++;
                if (exp_frm.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL frame_unexpected actual=%h required=none", rx);
                end else begin
                    ef = exp_frm.pop_front();
                    check("mosi_frame", {16'h0, rx & ef.mask}, {16'h0, ef.val & ef.mask});
                end
            end
        end
        if (!SS_n) begin
            if (sclk_prev && !SCLK) begin
                falls++;
                if (falls == 9) tx = {8'h00, reg_rd(rx[7:0], mdl_pr, mdl_az)};
                MISO = (falls >= 9) ? tx[16 - falls] : 1'b0;
            end
            if (!sclk_prev && SCLK) begin
                rx = {rx[14:0], MOSI};
                bits++;
            end
        end
        if (SS_n) begin
            hi_run++;
        end else if (hi_run > 0) begin
            if (seen_frame && hi_run < min_gap) min_gap = hi_run;
            hi_run = 0;
            seen_frame = 1'b1;
        end
        if (imu_err && !err_prev) err_cyc = cyc;
        err_prev = imu_err;
        ss_prev = SS_n;
        sclk_prev = SCLK;

        if (!rst_n) begin
            last_pr = 16'h0;
            last_az = 16'h0;
            last_rd = rd_frames;
        end else if (vld) begin
            vld_cnt++;
            if (exp_out.size() == 0) begin
                checks++; failures++;
                $display("FAIL vld_unexpected actual=%h_%h required=none", ptch_rt, AZ);
            end else begin
                eo = exp_out.pop_front();
                check("ptch_rt", {16'h0, ptch_rt}, {16'h0, eo.pr});
                check("AZ", {16'h0, AZ}, {16'h0, eo.az});
            end
            check("frames_per_vld", rd_frames - last_rd, 4);
            last_rd = rd_frames;
            last_pr = ptch_rt;
            last_az = AZ;
        end else if (ptch_rt !== last_pr || AZ !== last_az) begin
            hold_err++;
        end
    end

    task automatic push_init();
        exp_frm.push_back('{16'h0D02, 16'hFFFF});
        exp_frm.push_back('{16'h1053, 16'hFFFF});
        exp_frm.push_back('{16'h1150, 16'hFFFF});
        exp_frm.push_back('{16'h1460, 16'hFFFF});
    endtask

    task automatic push_read(input logic [15:0] pr, input logic [15:0] az);
        exp_frm.push_back('{16'hA200, 16'hFF00});
        exp_frm.push_back('{16'hA300, 16'hFF00});
        exp_frm.push_back('{16'hAC00, 16'hFF00});
        exp_frm.push_back('{16'hAD00, 16'hFF00});
        exp_out.push_back('{pr, az});
    endtask

    function automatic int get_cnt(input int sel);
        case (sel)
            0:       return frames_done;
            1:       return started;
            default: return vld_cnt;
        endcase
    endfunction

    // Bounded wait on a monitor counter; an expired budget is a failure.
    task automatic wait_cnt(input string name, input int sel, input int target, input int budget);
        int n = 0;
        while (get_cnt(sel) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (get_cnt(sel) < target) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d required=%0d", name, get_cnt(sel), target);
        end
    endtask

    task automatic pulse_int();
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
    endtask

    initial begin
        int v0;
        int s0;
        int f0;
        int idle_bad;

        // 1: reset values, power-up idle, init sequence
        repeat (3) @(negedge clk);
        check("rst_SS_n", SS_n, 1);
        check("rst_SCLK", SCLK, 1);
        check("rst_MOSI", MOSI, 0);
        check("rst_ptch_rt", ptch_rt, 0);
        check("rst_AZ", AZ, 0);
        check("rst_vld", vld, 0);
        check("rst_imu_err", imu_err, 0);
        push_init();
        rst_n = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (SS_n !== 1'b1 || SCLK !== 1'b1) idle_bad++;
        end
        check("pwrup_idle", idle_bad, 0);
        wait_cnt("init_frames", 0, 4, 4000);

        // 2: single read
        mdl_pr = 16'h1234; mdl_az = 16'hFF60;
        push_read(16'h1234, 16'hFF60);
        v0 = vld_cnt;
        pulse_int();
        wait_cnt("read1", 2, v0 + 1, 3000);
        repeat (20) @(negedge clk);
        check("read1_one_vld", vld_cnt, v0 + 1);

        // 3: sign extremes; INT pulse during a read is ignored
        mdl_pr = 16'h8000; mdl_az = 16'h7FFF;
        push_read(16'h8000, 16'h7FFF);
        v0 = vld_cnt; s0 = started;
        pulse_int();
        wait_cnt("read2_ph", 1, s0 + 2, 1500);
        pulse_int();
        wait_cnt("read2", 2, v0 + 1, 3000);
        repeat (30) @(negedge clk);
        check("int_ignored_vld", vld_cnt, v0 + 1);
        check("int_ignored_frames", started, s0 + 4);
        mdl_pr = 16'h7FFF; mdl_az = 16'h8000;
        push_read(16'h7FFF, 16'h8000);
        v0 = vld_cnt;
        pulse_int();
        wait_cnt("read3", 2, v0 + 1, 3000);

        // 4: INT held high, back-to-back reads
        push_read(16'h0001, 16'hFFFF);
        push_read(16'h4000, 16'hC000);
        push_read(16'h00FF, 16'hFF00);
        mdl_pr = 16'h0001; mdl_az = 16'hFFFF;
        v0 = vld_cnt; s0 = started;
        INT = 1'b1;
        wait_cnt("b2b1", 2, v0 + 1, 3000);
        mdl_pr = 16'h4000; mdl_az = 16'hC000;
        wait_cnt("b2b2", 2, v0 + 2, 3000);
        mdl_pr = 16'h00FF; mdl_az = 16'hFF00;
        wait_cnt("b2b3_ah", 1, s0 + 12, 3000);
        INT = 1'b0;
        wait_cnt("b2b3", 2, v0 + 3, 1500);
        repeat (40) @(negedge clk);
        check("b2b_vld_cnt", vld_cnt, v0 + 3);
        check("b2b_frames", started, s0 + 12);

        // 5: reset in the middle of RD_PH
        mdl_pr = 16'h5555; mdl_az = 16'hAAAA;
        exp_frm.push_back('{16'hA200, 16'hFF00});
        exp_frm.push_back('{16'hA300, 16'hFF00});
        s0 = started;
        pulse_int();
        wait_cnt("abort_ph", 1, s0 + 2, 1500);
        repeat (100) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_SS_n", SS_n, 1);
        check("abort_SCLK", SCLK, 1);
        check("abort_ptch_rt", ptch_rt, 0);
        check("abort_AZ", AZ, 0);
        exp_frm.delete();
        repeat (3) @(negedge clk);
        push_init();
        f0 = frames_done;
        rst_n = 1'b1;
        wait_cnt("reinit_frames", 0, f0 + 4, 4000);
        check("reinit_ptch_rt", ptch_rt, 0);
        check("reinit_AZ", AZ, 0);

`ifdef IMU_TIMEOUT_EN
        // 6: WAIT_INT timeout sets imu_err and re-runs the init sequence
        check("pre_timeout_err", imu_err, 0);
        push_init();
        f0 = frames_done;
        begin
            int n = 0;
            while (!imu_err && n < 400) begin
                @(negedge clk);
                n++;
            end
        end
        check("timeout_err", imu_err, 1);
        check("timeout_cycle", ((err_cyc - last_rise_cyc) >= 255 &&
                                (err_cyc - last_rise_cyc) <= 259) ? 1 : 0, 1);
        wait_cnt("timeout_reinit", 0, f0 + 4, 4000);
        check("err_sticky", imu_err, 1);
`else
        s0 = started;
        repeat (400) @(negedge clk);
        check("no_timeout_err", imu_err, 0);
        check("no_timeout_frames", started, s0);
`endif

        check("frames_left", exp_frm.size(), 0);
        check("outputs_left", exp_out.size(), 0);
        check("hold_between_vld", hold_err, 0);
        check("ss_gap_ok", (min_gap >= 1) ? 1 : 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
